// File: rtl/bc_fir_pkg.sv
// Shared types and constants for the binary FIR sample front end.
package bc_fir_pkg;

  localparam int NTAPS    = 39;
  localparam int SAMPLE_W = 12;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dl_state_e;

endpackage

// File: rtl/bc_fir_delay_line.sv
// FIR history window: shifts accepted samples into an NTAPS-deep line and presents
// each new window downstream; a flush drains the tail with zeros and empties the line.
module bc_fir_delay_line
  import bc_fir_pkg::*;
#(
  parameter int DW         = bc_fir_pkg::SAMPLE_W,
  parameter int NTAPS      = bc_fir_pkg::NTAPS,
  parameter bit PRIME_ZERO = 1'b0
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DW-1:0]              s_data,
  input  logic                       flush,
  output logic [NTAPS-1:0][DW-1:0]   taps,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [5:0]                 fill_cnt,
  output logic                       flush_done,
  output dl_state_e                  dbg_state
);

  localparam logic [5:0] FULL       = 6'(NTAPS);
  localparam logic [5:0] DRAIN_LAST = 6'(NTAPS - 1);

  dl_state_e     state;
  logic [5:0]    drain_cnt;
  logic          slot_free;
  logic          accept;
  logic          drain_ins;
  logic          drain_end;
  logic          win_set;
  logic [5:0]    fill_next;
  logic [DW-1:0] shift_in;

  // Handshakes: a transfer happens on a rising clock edge where valid && ready.
  // s_ready is combinational; a held window (win_valid && !win_ready) blocks the
  // line so taps never change under an unconsumed window.
  always_comb begin
    slot_free = !win_valid || win_ready;
    s_ready   = (state != DRAIN) && slot_free;
    accept    = s_valid && s_ready;
    drain_ins = (state == DRAIN) && slot_free && (drain_cnt != DRAIN_LAST);
    drain_end = (state == DRAIN) && slot_free && (drain_cnt == DRAIN_LAST);
    fill_next = (accept && (fill_cnt != FULL)) ? fill_cnt + 6'd1 : fill_cnt;
    win_set   = drain_ins || (accept && ((fill_next == FULL) || PRIME_ZERO));
    shift_in  = drain_ins ? '0 : s_data;
  end

  assign dbg_state = state;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      taps       <= '0;
      win_valid  <= 1'b0;
      fill_cnt   <= '0;
      flush_done <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      flush_done <= 1'b0;
      fill_cnt   <= fill_next;

      if (accept || drain_ins) begin
        taps <= {taps[NTAPS-2:0], shift_in};
      end

      if (win_set) begin
        win_valid <= 1'b1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end

      case (state)
        FILL, RUN: begin
          // A sample arriving with the flush is taken first, so test the post-accept count.
          if (flush) begin
            if (fill_next == 6'd0) begin
              flush_done <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else if (fill_next == FULL) begin
            state <= RUN;
          end
        end

        DRAIN: begin
          if (drain_ins) begin
            drain_cnt <= drain_cnt + 6'd1;
          end
          if (drain_end) begin
            taps       <= '0;
            fill_cnt   <= '0;
            win_valid  <= 1'b0;
            flush_done <= 1'b1;
            state      <= FILL;
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_bc_fir_delay_line.sv
// Bench for bc_fir_delay_line: directed vector table, drain/reset sequences and a
// randomized run against a queue-based model of the sample history.
module tb_bc_fir_delay_line;
  import bc_fir_pkg::*;

  localparam int W = 12;
  localparam int N = 39;

  typedef logic [N-1:0][W-1:0] taps_t;

  typedef struct {
    logic         sv;
    logic [W-1:0] d;
    logic         fl;
    logic         wr;
    logic         e_rdy;
    logic         e_wv;
    logic [5:0]   e_fill;
    logic [W-1:0] e_t0;
    logic [W-1:0] e_tl;
    logic         e_fd;
  } vec_t;

  // clock / reset
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  // DUT with PRIME_ZERO = 0
  logic         s_valid = 1'b0, s_ready, flush = 1'b0, win_valid, win_ready = 1'b0, flush_done;
  logic [W-1:0] s_data = '0;
  taps_t        taps;
  logic [5:0]   fill_cnt;
  dl_state_e    dbg_state;

  // DUT with PRIME_ZERO = 1
  logic         p_s_valid = 1'b0, p_s_ready, p_flush = 1'b0, p_win_valid, p_win_ready = 1'b1, p_flush_done;
  logic [W-1:0] p_s_data = '0;
  taps_t        p_taps;
  logic [5:0]   p_fill_cnt;
  dl_state_e    p_dbg_state;

  bc_fir_delay_line #(.DW(W), .NTAPS(N), .PRIME_ZERO(1'b0)) dut (
    .clock(clock), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush), .taps(taps), .win_valid(win_valid), .win_ready(win_ready),
    .fill_cnt(fill_cnt), .flush_done(flush_done), .dbg_state(dbg_state)
  );

  bc_fir_delay_line #(.DW(W), .NTAPS(N), .PRIME_ZERO(1'b1)) dut_pz (
    .clock(clock), .rst_n(rst_n), .s_valid(p_s_valid), .s_ready(p_s_ready), .s_data(p_s_data),
    .flush(p_flush), .taps(p_taps), .win_valid(p_win_valid), .win_ready(p_win_ready),
    .fill_cnt(p_fill_cnt), .flush_done(p_flush_done), .dbg_state(p_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_taps(input string name, input taps_t act, input taps_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < N; k++) begin
        if (act[k] !== exp[k]) begin
          $display("FAIL %s: taps[%0d] got %0h expected %0h", name, k, act[k], exp[k]);
          break;
        end
      end
    end
  endtask

  // ---------------- reference model ----------------
  // History as a queue, newest first; the window is its first N entries padded with zeros.
  logic [W-1:0] hist[$];
  int  m_fill;
  bit  m_drain;
  int  m_drain_left;
  bit  m_wv;
  bit  m_fd;

  task automatic model_reset();
    hist.delete();
    m_fill = 0; m_drain = 0; m_drain_left = 0; m_wv = 0; m_fd = 0;
  endtask

  task automatic model_push(input logic [W-1:0] x);
    hist.push_front(x);
    if (hist.size() > N) void'(hist.pop_back());
  endtask

  function automatic taps_t model_taps();
    taps_t t = '0;
    for (int k = 0; k < hist.size(); k++) t[k] = hist[k];
    return t;
  endfunction

  function automatic bit model_ready(input bit wr);
    return !m_drain && (!m_wv || wr);
  endfunction

  task automatic model_step(input bit sv, input logic [W-1:0] d, input bit fl, input bit wr);
    bit free, acc, nwv, nfd;
    free = !m_wv || wr;
    acc  = sv && model_ready(wr);
    nwv  = m_wv && !wr;
    nfd  = 0;
    if (m_drain) begin
      if (free) begin
        if (m_drain_left > 0) begin
          model_push('0);
          m_drain_left--;
          nwv = 1;
        end else begin
          hist.delete();
          m_fill = 0; m_drain = 0; nwv = 0; nfd = 1;
        end
      end
    end else begin
      if (acc) begin
        model_push(d);
        if (m_fill < N) m_fill++;
        if (m_fill == N) nwv = 1;
      end
      if (fl) begin
        if (m_fill == 0) nfd = 1;
        else begin m_drain = 1; m_drain_left = N - 1; end
      end
    end
    m_wv = nwv;
    m_fd = nfd;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    s_valid = 0; s_data = '0; flush = 0; win_ready = 1;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst_n = 0;
    @(negedge clock);
    rst_n = 1;
    model_reset();
  endtask

  task automatic push_sample(input logic [W-1:0] d);
    s_valid = 1; s_data = d; win_ready = 1; flush = 0;
    @(posedge clock);
    @(negedge clock);
    s_valid = 0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    s_valid = v.sv; s_data = v.d; flush = v.fl; win_ready = v.wr;
    #1;
    chk($sformatf("vec%0d_s_ready", idx), s_ready, v.e_rdy);
    @(posedge clock);
    @(negedge clock);
    chk($sformatf("vec%0d_win_valid", idx), win_valid, v.e_wv);
    chk($sformatf("vec%0d_fill_cnt", idx), fill_cnt, v.e_fill);
    chk($sformatf("vec%0d_taps0", idx), taps[0], v.e_t0);
    chk($sformatf("vec%0d_tapslast", idx), taps[N-1], v.e_tl);
    chk($sformatf("vec%0d_flush_done", idx), flush_done, v.e_fd);
  endtask

  function automatic vec_t mk(input logic sv, input int d, input logic fl, input logic wr,
                              input logic rdy, input logic wv, input int fill,
                              input int t0, input int tl, input logic fd);
    vec_t v;
    v.sv = sv; v.d = W'(d); v.fl = fl; v.wr = wr; v.e_rdy = rdy; v.e_wv = wv;
    v.e_fill = 6'(fill); v.e_t0 = W'(t0); v.e_tl = W'(tl); v.e_fd = fd;
    return v;
  endfunction

  task automatic rand_cycle(input int flush_odds);
    s_valid   = ($urandom_range(0, 9) < 7);
    s_data    = W'($urandom_range(0, 4095));
    flush     = ($urandom_range(0, flush_odds) == 0);
    win_ready = ($urandom_range(0, 3) != 0);
    #1;
    chk("rand_s_ready", s_ready, model_ready(win_ready));
    @(posedge clock);
    model_step(s_valid, s_data, flush, win_ready);
    @(negedge clock);
    chk("rand_win_valid", win_valid, m_wv);
    chk("rand_fill_cnt", fill_cnt, 32'(m_fill));
    chk("rand_flush_done", flush_done, m_fd);
    chk_taps("rand_taps", taps, model_taps());
  endtask

  // ---------------- test sequence ----------------
  vec_t  vecs[11];
  taps_t exp_t;

  initial begin
    vecs[0]  = mk(1, 40, 0, 1,  1, 1, 39, 40, 2, 0);
    vecs[1]  = mk(1, 41, 0, 1,  1, 1, 39, 41, 3, 0);
    for (int i = 2; i <= 6; i++) vecs[i] = mk(1, 42, 0, 0,  0, 1, 39, 41, 3, 0);
    vecs[7]  = mk(1, 42, 0, 1,  1, 1, 39, 42, 4, 0);
    vecs[8]  = mk(0, 0,  0, 1,  1, 0, 39, 42, 4, 0);
    vecs[9]  = mk(0, 0,  1, 1,  1, 0, 39, 42, 4, 0);
    vecs[10] = mk(1, 99, 0, 1,  0, 1, 39, 0,  5, 0);

    idle_inputs();
    rst_n = 0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_win_valid", win_valid, 0);
    chk("reset_fill_cnt", fill_cnt, 0);
    chk("reset_flush_done", flush_done, 0);
    chk("reset_s_ready", s_ready, 1);
    chk("reset_state", 32'(dbg_state), 32'(FILL));
    chk_taps("reset_taps", taps, '0);
    rst_n = 1;
    @(negedge clock);

    // fill with 1..39; the only window appears after the 39th sample
    for (int k = 1; k <= N; k++) begin
      push_sample(W'(k));
      chk($sformatf("fill%0d_win_valid", k), win_valid, (k == N));
      chk($sformatf("fill%0d_fill_cnt", k), fill_cnt, 32'(k));
    end
    chk("fill_taps0", taps[0], 39);
    chk("fill_tapslast", taps[N-1], 1);
    chk("fill_state", 32'(dbg_state), 32'(RUN));

    for (int i = 0; i < 11; i++) apply_vec(vecs[i], i);

    // remaining drain windows: zeros enter at the front, history walks to the end
    for (int k = 2; k <= N - 1; k++) begin
      s_valid = 1; s_data = W'($urandom_range(1, 4095)); win_ready = 1;
      #1;
      chk($sformatf("drain%0d_s_ready", k), s_ready, 0);
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("drain%0d_win_valid", k), win_valid, 1);
      chk($sformatf("drain%0d_tapslast", k), taps[N-1], 32'(4 + k));
      chk($sformatf("drain%0d_taps0", k), taps[0], 0);
    end
    exp_t = '0;
    exp_t[N-1] = W'(42);
    chk_taps("drain_last_window", taps, exp_t);
    s_valid = 0;
    @(posedge clock);
    @(negedge clock);
    chk("drain_end_flush_done", flush_done, 1);
    chk("drain_end_win_valid", win_valid, 0);
    chk("drain_end_fill_cnt", fill_cnt, 0);
    chk("drain_end_state", 32'(dbg_state), 32'(FILL));
    chk_taps("drain_end_taps", taps, '0);
    @(posedge clock);
    @(negedge clock);
    chk("drain_after_flush_done", flush_done, 0);

    // flush on an empty line: immediate done, no window
    flush = 1;
    @(posedge clock);
    @(negedge clock);
    flush = 0;
    chk("empty_flush_done", flush_done, 1);
    chk("empty_flush_win_valid", win_valid, 0);
    chk("empty_flush_state", 32'(dbg_state), 32'(FILL));
    @(posedge clock);
    @(negedge clock);
    chk("empty_flush_done_clear", flush_done, 0);

    // randomized traffic against the model
    reset_pulse();
    for (int c = 0; c < 2500; c++) rand_cycle(70);

    // reset in the middle of a drain
    reset_pulse();
    for (int k = 1; k <= N; k++) push_sample(W'($urandom_range(1, 4095)));
    flush = 1;
    @(posedge clock);
    @(negedge clock);
    flush = 0;
    repeat (10) @(negedge clock);
    chk("mid_drain_state", 32'(dbg_state), 32'(DRAIN));
    #2 rst_n = 0;
    #1;
    chk("async_rst_win_valid", win_valid, 0);
    chk("async_rst_fill_cnt", fill_cnt, 0);
    chk("async_rst_flush_done", flush_done, 0);
    chk("async_rst_s_ready", s_ready, 1);
    chk("async_rst_state", 32'(dbg_state), 32'(FILL));
    chk_taps("async_rst_taps", taps, '0);
    @(negedge clock);
    rst_n = 1;
    model_reset();
    begin
      int fd_seen = 0;
      for (int c = 0; c < N + 4; c++) begin
        @(negedge clock);
        if (flush_done || win_valid) fd_seen++;
      end
      chk("post_rst_no_flush_done", fd_seen, 0);
    end

    // PRIME_ZERO = 1: first sample yields a window at once
    p_s_valid = 1; p_s_data = W'(7);
    @(posedge clock);
    @(negedge clock);
    p_s_valid = 0;
    exp_t = '0;
    exp_t[0] = W'(7);
    chk("pz_win_valid", p_win_valid, 1);
    chk("pz_fill_cnt", p_fill_cnt, 1);
    chk_taps("pz_taps", p_taps, exp_t);
    p_s_valid = 1; p_s_data = W'(8);
    @(posedge clock);
    @(negedge clock);
    p_s_valid = 0;
    exp_t[1] = W'(7);
    exp_t[0] = W'(8);
    chk("pz2_win_valid", p_win_valid, 1);
    chk_taps("pz2_taps", p_taps, exp_t);
    @(posedge clock);
    @(negedge clock);
    chk("pz_win_clear", p_win_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
